sm_dmem_bridge: RTL

- Data-memory-side bus stage directly downstream of the CPU data port (dmAddr/dmWe/dmWData/dmRData).
- Decodes each CPU data access and routes it to one of three targets: on-chip data RAM, memory-mapped GPIO registers, or a compare/match timer.
- Returns read data in the same cycle, because the CPU is single-cycle.
- Holds all peripheral state and drives a level interrupt request.

---
 rtl/sm_dmem_bridge.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sm_dmem_bridge.sv
// Data-memory bus stage: decodes CPU data accesses to on-chip RAM, GPIO registers
// or a compare/match timer, returns read data combinationally and drives a level irq.
module sm_dmem_bridge #(
    parameter int RAM_AW = 8,
    parameter int GPIO_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       dmAddr,
    input  logic              dmWe,
    input  logic [31:0]       dmWData,
    output logic [31:0]       dmRData,
    output logic [RAM_AW-1:0] ramAddr,
    output logic              ramWe,
    output logic [31:0]       ramWData,
    input  logic [31:0]       ramRData,
    input  logic [GPIO_W-1:0] gpioIn,
    output logic [GPIO_W-1:0] gpioOut,
    output logic              irq
);

    localparam logic [5:0] OFF_GPIO_OUT = 6'd0;
    localparam logic [5:0] OFF_GPIO_IN  = 6'd1;
    localparam logic [5:0] OFF_TMR_CNT  = 6'd2;
    localparam logic [5:0] OFF_TMR_CMP  = 6'd3;
    localparam logic [5:0] OFF_TMR_CTRL = 6'd4;
    localparam logic [5:0] OFF_TMR_STAT = 6'd5;

    logic [GPIO_W-1:0] r_gpio_out;
    logic [GPIO_W-1:0] r_gpio_sync1;
    logic [GPIO_W-1:0] r_gpio_sync2;
    logic [31:0]       r_cnt;
    logic [31:0]       r_cmp;
    logic [2:0]        r_ctrl;
    logic              r_match;

    logic              w_sel_ram;
    logic              w_sel_per;
    logic [5:0]        w_off;
    logic              w_wr_per;
    logic              w_en;
    logic              w_hit;
    logic [31:0]       w_cnt_nxt;
    logic              w_match_nxt;
    logic [31:0]       w_rdata;
    logic [31:0]       w_gpio_out_ext;
    logic [31:0]       w_gpio_in_ext;
    logic              w_unused;

    assign w_sel_ram = (dmAddr[31:16] == 16'h0000);
    assign w_sel_per = (dmAddr[31:8] == 24'h000100);
    assign w_off     = dmAddr[7:2];
    assign w_wr_per  = dmWe & w_sel_per;
    assign w_unused  = &{1'b0, dmAddr[1:0]};

    // Upper address bits beyond the RAM depth are dropped, so large offsets alias.
    assign ramAddr   = dmAddr[RAM_AW+1:2];
    assign ramWe     = dmWe & w_sel_ram;
    assign ramWData  = dmWData;

    assign w_en      = r_ctrl[0];
    assign w_hit     = w_en & (r_cnt == r_cmp);
    assign irq       = r_match & r_ctrl[2];
    assign gpioOut   = r_gpio_out;
    assign dmRData   = w_rdata;

    // Timer next state: a CPU write to CNT overrides counting; a new match beats W1C.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_match_nxt = r_match;
        if (w_wr_per && (w_off == OFF_TMR_CNT)) begin
            w_cnt_nxt = dmWData;
        end else if (w_en) begin
            if (w_hit && r_ctrl[1]) begin
                w_cnt_nxt = 32'h0000_0000;
            end else begin
                w_cnt_nxt = r_cnt + 32'd1;
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end
        if (w_hit) begin
            w_match_nxt = 1'b1;
        end else if (w_wr_per && (w_off == OFF_TMR_STAT) && dmWData[0]) begin
            w_match_nxt = 1'b0;
        end else begin
            w_match_nxt = r_match;
        end
    end

    // Peripheral register state, GPIO input synchronizer and timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gpio_out   <= '0;
            r_gpio_sync1 <= '0;
            r_gpio_sync2 <= '0;
            r_cnt        <= 32'h0000_0000;
            r_cmp        <= 32'hFFFF_FFFF;
            r_ctrl       <= 3'b000;
            r_match      <= 1'b0;
        end else begin
            r_gpio_sync1 <= gpioIn;
            r_gpio_sync2 <= r_gpio_sync1;
            r_cnt        <= w_cnt_nxt;
            r_match      <= w_match_nxt;
            if (w_wr_per && (w_off == OFF_GPIO_OUT)) begin
                r_gpio_out <= dmWData[GPIO_W-1:0];
            end
            if (w_wr_per && (w_off == OFF_TMR_CMP)) begin
                r_cmp <= dmWData;
            end
            if (w_wr_per && (w_off == OFF_TMR_CTRL)) begin
                r_ctrl <= dmWData[2:0];
            end
        end
    end

    // Zero-extension of the GPIO registers onto the 32-bit read bus.
    always_comb begin
        w_gpio_out_ext               = 32'h0000_0000;
        w_gpio_in_ext                = 32'h0000_0000;
        w_gpio_out_ext[GPIO_W-1:0]   = r_gpio_out;
        w_gpio_in_ext[GPIO_W-1:0]    = r_gpio_sync2;
    end

    // Same-cycle read mux; unmapped space and unused offsets read as zero.
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (w_sel_ram) begin
            w_rdata = ramRData;
        end else if (w_sel_per) begin
            case (w_off)
                OFF_GPIO_OUT: w_rdata = w_gpio_out_ext;
                OFF_GPIO_IN:  w_rdata = w_gpio_in_ext;
                OFF_TMR_CNT:  w_rdata = r_cnt;
                OFF_TMR_CMP:  w_rdata = r_cmp;
                OFF_TMR_CTRL: w_rdata = {29'h0000_0000, r_ctrl};
                OFF_TMR_STAT: w_rdata = {31'h0000_0000, r_match};
                default:      w_rdata = 32'h0000_0000;
            endcase
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

endmodule
